// File: rtl/imuldiv_div_client.sv
// imuldiv_div_client: initiator-side front end for the iterative divider.
// Takes one divide command, issues it on divreq, waits for divresp, and
// returns the selected half (quotient or remainder) on the out port.
// It also records how many cycles the divider took to respond.
// Optional feature: define IMULDIV_DIV_CLIENT_ZERO_BYPASS_EN to answer
// divide-by-zero locally, without involving the divider.
`timescale 1ns/1ps

module imuldiv_div_client #(
    parameter int LAT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_msg_fn,
    input  logic             cmd_msg_sel,
    input  logic [31:0]      cmd_msg_a,
    input  logic [31:0]      cmd_msg_b,
    input  logic             cmd_val,
    output logic             cmd_rdy,
    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    output logic [31:0]      out_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [LAT_W-1:0] last_latency
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             sel_r;
    logic [LAT_W-1:0] lat_cnt_r;
    logic [LAT_W-1:0] lat_inc_s;
    logic             cmd_fire_s;
    logic             divreq_fire_s;
    logic             divresp_fire_s;
    logic             out_fire_s;
    logic             zero_bypass_s;

    // Handshake outputs are pure decodes of the state register, so they
    // never glitch on input changes and drop immediately under reset.
    assign cmd_rdy     = (state_r == ST_IDLE);
    assign divreq_val  = (state_r == ST_ISSUE);
    assign divresp_rdy = (state_r == ST_WAIT);
    assign out_val     = (state_r == ST_OUT);

    assign cmd_fire_s     = cmd_val     & cmd_rdy;
    assign divreq_fire_s  = divreq_val  & divreq_rdy;
    assign divresp_fire_s = divresp_val & divresp_rdy;
    assign out_fire_s     = out_val     & out_rdy;

`ifdef IMULDIV_DIV_CLIENT_ZERO_BYPASS_EN
    assign zero_bypass_s = (cmd_msg_b == 32'd0);
`else
    assign zero_bypass_s = 1'b0;
`endif

    // The reported latency counts the response cycle itself, so it is the
    // saturating successor of the running count.
    assign lat_inc_s = (lat_cnt_r == LAT_MAX) ? LAT_MAX : (lat_cnt_r + LAT_ONE);

    // Next-state selection: one operation walks IDLE->ISSUE->WAIT->OUT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    state_nxt_s = zero_bypass_s ? ST_OUT : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (divreq_fire_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (divresp_fire_s) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (out_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, latency counting and result selection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r         <= 1'b0;
            divreq_msg_fn <= 1'b0;
            divreq_msg_a  <= 32'd0;
            divreq_msg_b  <= 32'd0;
            lat_cnt_r     <= {LAT_W{1'b0}};
            last_latency  <= {LAT_W{1'b0}};
            out_msg       <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        sel_r         <= cmd_msg_sel;
                        divreq_msg_fn <= cmd_msg_fn;
                        divreq_msg_a  <= cmd_msg_a;
                        divreq_msg_b  <= cmd_msg_b;
                        if (zero_bypass_s) begin
                            // Local answer matches what the divider returns for b==0.
                            out_msg      <= cmd_msg_sel ? cmd_msg_a : 32'hFFFF_FFFF;
                            last_latency <= {LAT_W{1'b0}};
                        end
                    end
                end
                ST_ISSUE: begin
                    if (divreq_fire_s) begin
                        lat_cnt_r <= {LAT_W{1'b0}};
                    end
                end
                ST_WAIT: begin
                    if (divresp_fire_s) begin
                        out_msg      <= sel_r ? divresp_msg_result[63:32]
                                              : divresp_msg_result[31:0];
                        last_latency <= lat_inc_s;
                    end else begin
                        lat_cnt_r <= lat_inc_s;
                    end
                end
                ST_OUT: begin
                    out_msg <= out_msg;
                end
                default: begin
                    lat_cnt_r <= lat_cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imuldiv_div_client.sv
// Self-checking bench for imuldiv_div_client. The bench plays both the
// command source, the divider responder and the result sink.
`timescale 1ns/1ps

module tb_imuldiv_div_client;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_msg_fn, cmd_msg_sel;
    logic [31:0] cmd_msg_a, cmd_msg_b;
    logic        cmd_val, cmd_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;
    logic [31:0] out_msg;
    logic        out_val, out_rdy;
    logic [15:0] last_latency;

    // second instance with a narrow latency counter, fed the same inputs
    logic        cmd_rdy4, divreq_msg_fn4, divreq_val4, divresp_rdy4, out_val4;
    logic [31:0] divreq_msg_a4, divreq_msg_b4, out_msg4;
    logic [3:0]  last_latency4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imuldiv_div_client #(.LAT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_msg_fn(cmd_msg_fn), .cmd_msg_sel(cmd_msg_sel),
        .cmd_msg_a(cmd_msg_a), .cmd_msg_b(cmd_msg_b),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
        .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy),
        .last_latency(last_latency)
    );

    imuldiv_div_client #(.LAT_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .cmd_msg_fn(cmd_msg_fn), .cmd_msg_sel(cmd_msg_sel),
        .cmd_msg_a(cmd_msg_a), .cmd_msg_b(cmd_msg_b),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy4),
        .divreq_msg_fn(divreq_msg_fn4), .divreq_msg_a(divreq_msg_a4), .divreq_msg_b(divreq_msg_b4),
        .divreq_val(divreq_val4), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy4),
        .out_msg(out_msg4), .out_val(out_val4), .out_rdy(out_rdy),
        .last_latency(last_latency4)
    );

    // Divider behaviour as a responder would compute it: {remainder, quotient}.
    function automatic logic [63:0] ref_div(input logic fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (fn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (fn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // One full operation, starting and ending at a negedge with the DUT idle.
    task automatic run_op(input logic fn, input logic sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input int req_wait, input int resp_lat,
                          input int out_wait);
        logic        bypass;
        logic [63:0] res;
        logic [15:0] exp_lat;
        logic [3:0]  exp_lat4;
`ifdef IMULDIV_DIV_CLIENT_ZERO_BYPASS_EN
        bypass = (b == 32'd0);
`else
        bypass = 1'b0;
`endif
        res = ref_div(fn, a, b);
        checks++;
        if (cmd_rdy !== 1'b1 || out_val !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: cmd_rdy=%b out_val=%b, required 1 0", cmd_rdy, out_val);
        end
        cmd_val = 1'b1; cmd_msg_fn = fn; cmd_msg_sel = sel; cmd_msg_a = a; cmd_msg_b = b;
        @(negedge clk);
        // garbage command that must not be accepted while busy
        cmd_val = 1'b1; cmd_msg_fn = 1'($urandom); cmd_msg_sel = 1'($urandom);
        cmd_msg_a = $urandom; cmd_msg_b = $urandom;
        if (bypass) begin
            exp_lat = 16'd0;
            checks++;
            if (divreq_val !== 1'b0 || out_val !== 1'b1) begin
                errors++;
                $display("FAIL bypass_path: divreq_val=%b out_val=%b, required 0 1", divreq_val, out_val);
            end
        end else begin
            divresp_val = 1'($urandom);
            divresp_msg_result = {$urandom, $urandom};
            for (int i = 0; i <= req_wait; i++) begin
                if (i == req_wait) divreq_rdy = 1'b1;
                checks++;
                if ({cmd_rdy, divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b} !== {1'b0, 1'b1, fn, a, b}) begin
                    errors++;
                    $display("FAIL divreq_hold: rdy/val/fn/a/b=%b %b %b %h %h, required 0 1 %b %h %h",
                             cmd_rdy, divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b, fn, a, b);
                end
                @(negedge clk);
            end
            divreq_rdy = 1'b0;
            divresp_val = 1'b0;
            for (int k = 1; k <= resp_lat; k++) begin
                if (k == resp_lat) begin
                    divresp_val = 1'b1;
                    divresp_msg_result = res;
                end
                checks++;
                if ({divresp_rdy, divreq_val, out_val, cmd_rdy} !== 4'b1000) begin
                    errors++;
                    $display("FAIL wait_state: resp_rdy/req_val/out_val/cmd_rdy=%b%b%b%b, required 1000",
                             divresp_rdy, divreq_val, out_val, cmd_rdy);
                end
                @(negedge clk);
            end
            exp_lat = (resp_lat > 65535) ? 16'hFFFF : 16'(resp_lat);
        end
        exp_lat4 = (resp_lat > 15 && !bypass) ? 4'hF : (bypass ? 4'h0 : 4'(resp_lat));
        // stale responses while in OUT must be ignored
        divresp_val = 1'($urandom);
        divresp_msg_result = {$urandom, $urandom};
        for (int j = 0; j <= out_wait; j++) begin
            if (j == out_wait) begin
                out_rdy = 1'b1;
                cmd_val = 1'b0;
                divresp_val = 1'b0;
            end
            checks++;
            if ({out_val, out_msg, cmd_rdy, divresp_rdy, divreq_val} !== {1'b1, exp_out, 3'b000}) begin
                errors++;
                $display("FAIL out_hold: out_val=%b out_msg=%h cmd_rdy=%b resp_rdy=%b req_val=%b, required 1 %h 0 0 0",
                         out_val, out_msg, cmd_rdy, divresp_rdy, divreq_val, exp_out);
            end
            @(negedge clk);
        end
        out_rdy = 1'b0;
        checks++;
        if (last_latency !== exp_lat) begin
            errors++;
            $display("FAIL last_latency: got %0d, required %0d", last_latency, exp_lat);
        end
        checks++;
        if (last_latency4 !== exp_lat4 || out_msg4 !== exp_out) begin
            errors++;
            $display("FAIL narrow_inst: latency %0d msg %h, required %0d %h", last_latency4, out_msg4, exp_lat4, exp_out);
        end
        checks++;
        if (cmd_rdy !== 1'b1 || out_val !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: cmd_rdy=%b out_val=%b, required 1 0", cmd_rdy, out_val);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_val = 1'b0; cmd_msg_fn = 1'b0; cmd_msg_sel = 1'b0; cmd_msg_a = 32'd0; cmd_msg_b = 32'd0;
        divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = 64'd0; out_rdy = 1'b0;
        #1;
        checks++;
        if ({cmd_rdy, divreq_val, divresp_rdy, out_val, out_msg, divreq_msg_fn, divreq_msg_a, divreq_msg_b, last_latency}
            !== {4'b1000, 32'd0, 1'b0, 64'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_values: rdy/val %b%b%b%b out_msg %h lat %0d", cmd_rdy, divreq_val,
                     divresp_rdy, out_val, out_msg, last_latency);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 0, 1, 0);
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 0, 1, 0);
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 2, 1);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 3, 0);
    endtask

    task automatic test_stall();
        run_op(1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 5, 2, 3);
    endtask

    task automatic test_latency();
        run_op(1'b0, 1'b1, 32'd50, 32'd6, 32'd2, 0, 33, 0);
        run_op(1'b0, 1'b0, 32'd50, 32'd6, 32'd8, 0, 40, 0);
    endtask

    task automatic test_reset_mid();
        cmd_val = 1'b1; cmd_msg_fn = 1'b0; cmd_msg_sel = 1'b0; cmd_msg_a = 32'd20; cmd_msg_b = 32'd4;
        divreq_rdy = 1'b1;
        @(negedge clk);
        cmd_val = 1'b0;
        @(negedge clk);
        divreq_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({cmd_rdy, divreq_val, divresp_rdy, out_val, out_msg, divreq_msg_fn, divreq_msg_a, divreq_msg_b, last_latency}
            !== {4'b1000, 32'd0, 1'b0, 64'd0, 16'd0}) begin
            errors++;
            $display("FAIL async_reset_mid: rdy/val %b%b%b%b out_msg %h req_a %h lat %0d", cmd_rdy,
                     divreq_val, divresp_rdy, out_val, out_msg, divreq_msg_a, last_latency);
        end
        @(negedge clk);
        reset = 1'b0;
        divresp_val = 1'b1;
        divresp_msg_result = {32'd7, 32'd5};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({divresp_rdy, out_val, cmd_rdy} !== 3'b001) begin
                errors++;
                $display("FAIL stale_resp: resp_rdy/out_val/cmd_rdy=%b%b%b, required 001", divresp_rdy, out_val, cmd_rdy);
            end
        end
        divresp_val = 1'b0;
        run_op(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 0, 1, 0);
    endtask

    task automatic test_zero_div();
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 0, 2, 0);
        run_op(1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, 1);
    endtask

    task automatic test_random();
        logic        fn, sel;
        logic [31:0] a, b;
        logic [63:0] res;
        for (int n = 0; n < 25; n++) begin
            fn = 1'($urandom); sel = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            res = ref_div(fn, a, b);
            run_op(fn, sel, a, b, sel ? res[63:32] : res[31:0],
                   $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_latency();
        test_reset_mid();
        test_zero_div();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
